// File: rtl/i2c_pkg.sv
// Shared types and helpers for the I2C bit-level sequencer.
package i2c_pkg;

    localparam int PRESCALE_W = 10;

    typedef enum logic [2:0] {
        CMD_START = 3'd1,
        CMD_STOP  = 3'd2,
        CMD_WRITE = 3'd3,
        CMD_READ  = 3'd4
    } cmd_t;

    typedef enum logic [2:0] {
        PH_IDLE = 3'd0,
        PH_Q0   = 3'd1,
        PH_Q1   = 3'd2,
        PH_Q2   = 3'd3,
        PH_Q3   = 3'd4
    } phase_t;

    function automatic logic cmd_is_legal(input logic [2:0] c);
        return (c >= 3'd1) && (c <= 3'd4);
    endfunction

    // Returns {scl_oe, sda_oe} for a quarter of a bit; 1 means pull the line low.
    function automatic logic [1:0] quarter_drive(input cmd_t c, input phase_t ph, input logic d);
        logic [1:0] v;
        v = 2'b00;
        case (c)
            CMD_START: begin
                case (ph)
                    PH_Q0:   v = 2'b00;
                    PH_Q1:   v = 2'b01;
                    PH_Q2:   v = 2'b01;
                    PH_Q3:   v = 2'b11;
                    default: v = 2'b00;
                endcase
            end
            CMD_STOP: begin
                case (ph)
                    PH_Q0:   v = 2'b11;
                    PH_Q1:   v = 2'b01;
                    PH_Q2:   v = 2'b00;
                    PH_Q3:   v = 2'b00;
                    default: v = 2'b00;
                endcase
            end
            CMD_WRITE: begin
                case (ph)
                    PH_Q0:   v = {1'b1, ~d};
                    PH_Q1:   v = {1'b0, ~d};
                    PH_Q2:   v = {1'b0, ~d};
                    PH_Q3:   v = {1'b1, ~d};
                    default: v = 2'b00;
                endcase
            end
            CMD_READ: begin
                case (ph)
                    PH_Q0:   v = 2'b10;
                    PH_Q1:   v = 2'b00;
                    PH_Q2:   v = 2'b00;
                    PH_Q3:   v = 2'b10;
                    default: v = 2'b00;
                endcase
            end
            default: v = 2'b00;
        endcase
        return v;
    endfunction

endpackage

// File: rtl/i2c_quarter_timer.sv
// Quarter-bit timer: counts 0..i_load, ticks on the last count, freezes while held.
module i2c_quarter_timer #(
    parameter int W = 10
) (
    input  logic         i_clk,
    input  logic         i_reset,
    input  logic         i_clear,
    input  logic         i_hold,
    input  logic [W-1:0] i_load,
    output logic         o_tick
);

    logic [W-1:0] r_count;
    logic         w_tick;

    // A held counter never ticks, so a stretched quarter cannot end early.
    assign w_tick = (r_count == i_load) && !i_hold;
    assign o_tick = w_tick;

    // Count up, wrap to zero on tick, freeze while the clock is being stretched.
    always_ff @(posedge i_clk) begin
        if (i_reset) begin
            r_count <= '0;
        end else if (i_clear) begin
            r_count <= '0;
        end else if (!i_hold) begin
            if (w_tick) begin
                r_count <= '0;
            end else begin
                r_count <= r_count + 1'b1;
            end
        end
    end

endmodule

// File: rtl/i2c_bit_sequencer.sv
// I2C bit sequencer: executes START/STOP/WRITE/READ as four timed quarters,
// with clock stretching and arbitration-loss detection.
module i2c_bit_sequencer #(
    parameter int PRESCALE_W = i2c_pkg::PRESCALE_W
) (
    input  logic                  clk100mhz,
    input  logic                  reset,
    input  logic [PRESCALE_W-1:0] prescale,
    input  logic                  cmd_valid,
    output logic                  cmd_ready,
    input  logic [2:0]            cmd,
    input  logic                  cmd_data,
    output logic                  rsp_valid,
    output logic                  rsp_data,
    output logic                  arb_lost,
    output logic                  busy,
    output logic                  scl_oe,
    output logic                  sda_oe,
    input  logic                  scl_in,
    input  logic                  sda_in
);

    import i2c_pkg::*;

    phase_t                r_state;
    cmd_t                  r_cmd;
    logic                  r_d;
    logic [PRESCALE_W-1:0] r_prescale;
    logic                  r_rd_bit;
    logic                  r_pend;
    logic                  r_pend_data;
    logic                  r_pend_arb;
    logic                  r_scl_oe;
    logic                  r_sda_oe;
    logic                  r_rsp_valid;
    logic                  r_rsp_data;
    logic                  r_arb_lost;

    logic                  w_tick;
    logic                  w_clear;
    logic                  w_hold;

    // The counter sits at zero in IDLE so every command starts with a fresh quarter.
    assign w_clear = (r_state == PH_IDLE);
    // Another master or slave holding SCL low while we release it stretches the quarter.
    assign w_hold  = (r_state != PH_IDLE) && !r_scl_oe && !scl_in;

    i2c_quarter_timer #(
        .W (PRESCALE_W)
    ) u_timer (
        .i_clk   (clk100mhz),
        .i_reset (reset),
        .i_clear (w_clear),
        .i_hold  (w_hold),
        .i_load  (r_prescale),
        .o_tick  (w_tick)
    );

    assign cmd_ready = (r_state == PH_IDLE);
    assign busy      = (r_state != PH_IDLE);
    assign scl_oe    = r_scl_oe;
    assign sda_oe    = r_sda_oe;
    assign rsp_valid = r_rsp_valid;
    assign rsp_data  = r_rsp_data;
    assign arb_lost  = r_arb_lost;

    // Sequencer FSM; completion is staged through r_pend so the response lands one
    // edge after the state returns to IDLE.
    always_ff @(posedge clk100mhz) begin
        if (reset) begin
            r_state     <= PH_IDLE;
            r_cmd       <= CMD_START;
            r_d         <= 1'b0;
            r_prescale  <= '0;
            r_rd_bit    <= 1'b0;
            r_pend      <= 1'b0;
            r_pend_data <= 1'b0;
            r_pend_arb  <= 1'b0;
            r_scl_oe    <= 1'b0;
            r_sda_oe    <= 1'b0;
            r_rsp_valid <= 1'b0;
            r_rsp_data  <= 1'b0;
            r_arb_lost  <= 1'b0;
        end else begin
            r_pend      <= 1'b0;
            r_rsp_valid <= r_pend;
            r_rsp_data  <= r_pend & r_pend_data;
            r_arb_lost  <= r_pend & r_pend_arb;

            case (r_state)
                PH_IDLE: begin
                    if (cmd_valid) begin
                        if (cmd_is_legal(cmd)) begin
                            r_cmd      <= cmd_t'(cmd);
                            r_d        <= cmd_data;
                            r_prescale <= prescale;
                            r_state    <= PH_Q0;
                            {r_scl_oe, r_sda_oe} <= quarter_drive(cmd_t'(cmd), PH_Q0, cmd_data);
                        end else begin
                            // Illegal code: acknowledge without touching the bus.
                            r_pend      <= 1'b1;
                            r_pend_data <= 1'b0;
                            r_pend_arb  <= 1'b0;
                        end
                    end
                end
                PH_Q0: begin
                    if (w_tick) begin
                        if ((r_cmd == CMD_START) && !sda_in) begin
                            r_state     <= PH_IDLE;
                            r_scl_oe    <= 1'b0;
                            r_sda_oe    <= 1'b0;
                            r_pend      <= 1'b1;
                            r_pend_data <= 1'b0;
                            r_pend_arb  <= 1'b1;
                        end else begin
                            r_state <= PH_Q1;
                            {r_scl_oe, r_sda_oe} <= quarter_drive(r_cmd, PH_Q1, r_d);
                        end
                    end
                end
                PH_Q1: begin
                    if (w_tick) begin
                        if ((r_cmd == CMD_WRITE) && r_d && !sda_in) begin
                            r_state     <= PH_IDLE;
                            r_scl_oe    <= 1'b0;
                            r_sda_oe    <= 1'b0;
                            r_pend      <= 1'b1;
                            r_pend_data <= 1'b0;
                            r_pend_arb  <= 1'b1;
                        end else begin
                            if (r_cmd == CMD_READ) begin
                                r_rd_bit <= sda_in;
                            end
                            r_state <= PH_Q2;
                            {r_scl_oe, r_sda_oe} <= quarter_drive(r_cmd, PH_Q2, r_d);
                        end
                    end
                end
                PH_Q2: begin
                    if (w_tick) begin
                        r_state <= PH_Q3;
                        {r_scl_oe, r_sda_oe} <= quarter_drive(r_cmd, PH_Q3, r_d);
                    end
                end
                PH_Q3: begin
                    // Lines keep their Q3 levels into IDLE, leaving SCL low between bits.
                    if (w_tick) begin
                        r_state     <= PH_IDLE;
                        r_pend      <= 1'b1;
                        r_pend_data <= (r_cmd == CMD_READ) ? r_rd_bit : 1'b0;
                        r_pend_arb  <= 1'b0;
                    end
                end
                default: begin
                    r_state <= PH_IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_i2c_bit_sequencer.sv
// Directed bench for the I2C bit sequencer.
module tb_i2c_bit_sequencer;

    logic       clk100mhz = 1'b0;
    logic       reset;
    logic [9:0] prescale;
    logic       cmd_valid;
    logic       cmd_ready;
    logic [2:0] cmd;
    logic       cmd_data;
    logic       rsp_valid;
    logic       rsp_data;
    logic       arb_lost;
    logic       busy;
    logic       scl_oe;
    logic       sda_oe;
    logic       scl_in;
    logic       sda_in;

    int n_vec = 0;
    int n_err = 0;

    int   edges;
    logic got_data;
    logic got_arb;
    logic seen;

    always #5 clk100mhz = ~clk100mhz;

    i2c_bit_sequencer #(.PRESCALE_W(10)) dut (
        .clk100mhz (clk100mhz),
        .reset     (reset),
        .prescale  (prescale),
        .cmd_valid (cmd_valid),
        .cmd_ready (cmd_ready),
        .cmd       (cmd),
        .cmd_data  (cmd_data),
        .rsp_valid (rsp_valid),
        .rsp_data  (rsp_data),
        .arb_lost  (arb_lost),
        .busy      (busy),
        .scl_oe    (scl_oe),
        .sda_oe    (sda_oe),
        .scl_in    (scl_in),
        .sda_in    (sda_in)
    );

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_vec++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic step();
        @(posedge clk100mhz);
        #1;
    endtask

    // Issue one command and count edges from the accepting edge to rsp_valid.
    // exp_drv packs {Q0,Q1,Q2,Q3} as {scl_oe,sda_oe} pairs, checked at each quarter start.
    task automatic run_cmd(input logic [2:0] c, input logic d, input int p,
                           input logic chk_drv, input logic [7:0] exp_drv,
                           input int st_at, input int st_len,
                           output int n, output logic dat, output logic arb);
        logic [7:0] ed;
        ed        = exp_drv;
        cmd       = c;
        cmd_data  = d;
        prescale  = 10'(p);
        cmd_valid = 1'b1;
        step();
        cmd_valid = 1'b0;
        cmd       = 3'd0;
        prescale  = 10'h3ff;
        n = 0;
        while (rsp_valid !== 1'b1 && n < 400) begin
            if (st_len > 0 && n == st_at) scl_in = 1'b0;
            if (st_len > 0 && n == st_at + st_len) scl_in = 1'b1;
            if (chk_drv && (n % (p + 1)) == 0 && (n / (p + 1)) < 4)
                chk("quarter_drive", 32'({scl_oe, sda_oe}), 32'(ed[7 - 2*(n/(p+1)) -: 2]));
            step();
            n++;
        end
        scl_in = 1'b1;
        dat = rsp_data;
        arb = arb_lost;
        chk("ready_with_rsp", 32'(cmd_ready), 32'd1);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

    initial begin
        reset     = 1'b1;
        prescale  = 10'd0;
        cmd_valid = 1'b0;
        cmd       = 3'd0;
        cmd_data  = 1'b0;
        scl_in    = 1'b1;
        sda_in    = 1'b1;
        repeat (3) step();
        reset = 1'b0;

        chk("rst_cmd_ready", 32'(cmd_ready), 32'd1);
        chk("rst_busy",      32'(busy),      32'd0);
        chk("rst_scl_oe",    32'(scl_oe),    32'd0);
        chk("rst_sda_oe",    32'(sda_oe),    32'd0);
        chk("rst_rsp_valid", 32'(rsp_valid), 32'd0);
        chk("rst_rsp_data",  32'(rsp_data),  32'd0);
        chk("rst_arb_lost",  32'(arb_lost),  32'd0);

        // START, P=24: 4*25+1 = 101 edges
        run_cmd(3'd1, 1'b0, 24, 1'b1, 8'b00_01_01_11, 0, 0, edges, got_data, got_arb);
        chk("start_latency", 32'(edges), 32'd101);
        chk("start_arb",     32'(got_arb), 32'd0);
        chk("start_idle_lines", 32'({scl_oe, sda_oe}), 32'b11);

        // WRITE d=0, P=24, back to back
        run_cmd(3'd3, 1'b0, 24, 1'b1, 8'b11_01_01_11, 0, 0, edges, got_data, got_arb);
        chk("write0_latency", 32'(edges), 32'd101);
        chk("write0_data",    32'(got_data), 32'd0);
        chk("write0_arb",     32'(got_arb), 32'd0);
        step();
        chk("rsp_one_cycle",  32'(rsp_valid), 32'd0);

        // READ, P=3, sda high then low
        sda_in = 1'b1;
        run_cmd(3'd4, 1'b0, 3, 1'b1, 8'b10_00_00_10, 0, 0, edges, got_data, got_arb);
        chk("read1_latency", 32'(edges), 32'd17);
        chk("read1_data",    32'(got_data), 32'd1);
        chk("read1_arb",     32'(got_arb), 32'd0);
        sda_in = 1'b0;
        run_cmd(3'd4, 1'b0, 3, 1'b1, 8'b10_00_00_10, 0, 0, edges, got_data, got_arb);
        sda_in = 1'b1;
        chk("read0_latency", 32'(edges), 32'd17);
        chk("read0_data",    32'(got_data), 32'd0);

        // WRITE d=1, P=3, SCL held low for 10 cycles from the start of Q1
        run_cmd(3'd3, 1'b1, 3, 1'b0, 8'h00, 4, 10, edges, got_data, got_arb);
        chk("stretch_latency", 32'(edges), 32'd27);
        chk("stretch_arb",     32'(got_arb), 32'd0);

        // WRITE d=1, P=3, SDA pulled low by someone else: lost at Q1 tick (edge 8)
        sda_in = 1'b0;
        run_cmd(3'd3, 1'b1, 3, 1'b0, 8'h00, 0, 0, edges, got_data, got_arb);
        sda_in = 1'b1;
        chk("warb_latency", 32'(edges), 32'd9);
        chk("warb_arb",     32'(got_arb), 32'd1);
        chk("warb_data",    32'(got_data), 32'd0);
        chk("warb_scl_oe",  32'(scl_oe), 32'd0);
        chk("warb_sda_oe",  32'(sda_oe), 32'd0);

        // START, P=3, SDA low at Q0 tick (edge 4)
        sda_in = 1'b0;
        run_cmd(3'd1, 1'b0, 3, 1'b0, 8'h00, 0, 0, edges, got_data, got_arb);
        sda_in = 1'b1;
        chk("sarb_latency", 32'(edges), 32'd5);
        chk("sarb_arb",     32'(got_arb), 32'd1);

        // Reset during Q2 of STOP (P=3: Q2 spans edges 8..11)
        cmd       = 3'd2;
        cmd_data  = 1'b0;
        prescale  = 10'd3;
        cmd_valid = 1'b1;
        step();
        cmd_valid = 1'b0;
        cmd       = 3'd0;
        repeat (9) step();
        chk("stop_busy_before_rst", 32'(busy), 32'd1);
        reset = 1'b1;
        step();
        reset = 1'b0;
        chk("midrst_cmd_ready", 32'(cmd_ready), 32'd1);
        chk("midrst_busy",      32'(busy),      32'd0);
        chk("midrst_lines",     32'({scl_oe, sda_oe}), 32'b00);
        chk("midrst_rsp_valid", 32'(rsp_valid), 32'd0);
        seen = 1'b0;
        for (int i = 0; i < 12; i++) begin
            step();
            if (rsp_valid === 1'b1) seen = 1'b1;
        end
        chk("midrst_no_stale_rsp", 32'(seen), 32'd0);

        // Park lines at (1,1) with WRITE d=0, then an illegal code must not touch them
        run_cmd(3'd3, 1'b0, 3, 1'b1, 8'b11_01_01_11, 0, 0, edges, got_data, got_arb);
        chk("park_latency", 32'(edges), 32'd17);
        run_cmd(3'd7, 1'b1, 0, 1'b1, 8'b11_00_00_00, 0, 0, edges, got_data, got_arb);
        chk("illegal_latency", 32'(edges), 32'd1);
        chk("illegal_lines",   32'({scl_oe, sda_oe}), 32'b11);
        chk("illegal_arb",     32'(got_arb), 32'd0);
        chk("illegal_busy",    32'(busy), 32'd0);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
